// File: rtl/adder_pkg.sv
// Shared constants, payload layout and configuration check for pipelined_adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Payload carried by one stage at the default width. adder_stage declares
  // the same layout sized by its own WIDTH parameter.
  typedef struct packed {
    logic                     carry;
    logic [DEFAULT_WIDTH-1:0] psum;
    logic [DEFAULT_WIDTH-1:0] op_a;
    logic [DEFAULT_WIDTH-1:0] op_b;
  } stage_payload_t;

  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline slice: adds chunk IDX of the operands plus the incoming carry,
// forwards the lower result bits and the operands, and holds while stalled.
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_WIDTH / DEFAULT_STAGES,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_psum,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic             dn_carry,
  output logic [WIDTH-1:0] dn_psum,
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b
);

  localparam int LO = IDX * CHUNK;

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
  } payload_t;

  payload_t         q;
  payload_t         d;
  logic             valid_q;
  logic             load;
  logic [CHUNK:0]   chunk_sum;

  assign load     = !valid_q || dn_ready;
  assign up_ready = load;

  assign chunk_sum = {1'b0, up_a[LO +: CHUNK]} + {1'b0, up_b[LO +: CHUNK]}
                   + {{CHUNK{1'b0}}, up_carry};

  // Next payload: insert this chunk's sum above the bits already resolved.
  always_comb begin
    d                 = '0;
    d.carry           = chunk_sum[CHUNK];
    d.psum            = up_psum;
    d.psum[LO +: CHUNK] = chunk_sum[CHUNK-1:0];
    d.op_a            = up_a;
    d.op_b            = up_b;
  end

  // Register slice; contents only change when a valid item is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (load) begin
      valid_q <= up_valid;
      if (up_valid) q <= d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_carry = q.carry;
  assign dn_psum  = q.psum;
  assign dn_a     = q.op_a;
  assign dn_b     = q.op_b;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined carry-ripple adder, STAGES registered chunks of WIDTH/STAGES bits,
// valid/ready on both sides. Define PIPELINED_ADDER_OVF_EN to add the signed
// overflow output ovf.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES");
  end

  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [STAGES:0] cy;
  logic [WIDTH-1:0] ps [STAGES+1];
  logic [WIDTH-1:0] pa [STAGES+1];
  logic [WIDTH-1:0] pb [STAGES+1];
  logic unused_ops;

  assign vld[0]      = in_valid;
  assign cy[0]       = cin;
  assign ps[0]       = '0;
  assign pa[0]       = a;
  assign pb[0]       = b;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (vld[k]),
      .up_ready (rdy[k]),
      .up_carry (cy[k]),
      .up_psum  (ps[k]),
      .up_a     (pa[k]),
      .up_b     (pb[k]),
      .dn_valid (vld[k+1]),
      .dn_ready (rdy[k+1]),
      .dn_carry (cy[k+1]),
      .dn_psum  (ps[k+1]),
      .dn_a     (pa[k+1]),
      .dn_b     (pb[k+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign sum       = ps[STAGES];
  assign cout      = cy[STAGES];

  // Operands leaving the last stage are only needed for the MSB carry.
  assign unused_ops = ^{pa[STAGES], pb[STAGES]};

`ifdef PIPELINED_ADDER_OVF_EN
  // Carry into the MSB is recovered from the registered MSBs of a, b and sum.
  assign ovf = ps[STAGES][WIDTH-1] ^ pa[STAGES][WIDTH-1] ^ pb[STAGES][WIDTH-1] ^ cy[STAGES];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic         ovf;
  localparam logic [W+1:0] MASK = {1'b1, 1'b1, {W{1'b1}}};
`else
  localparam logic [W+1:0] MASK = {1'b0, 1'b1, {W{1'b1}}};
`endif

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_in    = 0;
  int n_out   = 0;
  logic [W+1:0] exp_q[$];

  // Reference: {ovf, cout, sum}; ovf from operand/result sign comparison.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  function automatic logic [W+1:0] obs_word();
`ifdef PIPELINED_ADDER_OVF_EN
    return {ovf, cout, sum};
`else
    return {1'b0, cout, sum};
`endif
  endfunction

  task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, evaluate transfers, score outputs, advance.
  task automatic cycle(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic ordy);
    logic in_fire;
    logic out_fire;
    logic [W+1:0] e;
    in_valid  = iv;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = ordy;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_out: observed sum %h with no pending operand", sum);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("scoreboard", obs_word(), e & MASK);
      end
      n_out++;
    end
    if (in_fire) begin
      exp_q.push_back(model(x, y, c));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  // Send one operand into an empty pipe, wait for it, check hand-computed result.
  task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    cycle(1'b1, x, y, c, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      lat++;
    end
    check({tag, "_latency"}, lat, S);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
`ifdef PIPELINED_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo) n_tests = n_tests + 0;
`endif
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int base;
    logic [W-1:0] held;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed carries
    directed("chunk_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    directed("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    directed("cross_all", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    directed("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Streaming: back-to-back with out_ready high
    base = n_out;
    for (int i = 0; i < 100 + S; i++) begin
      if (i >= S) check("stream_out_valid", out_valid, 1);
      if (i < 100) begin
        cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        check("stream_in_ready", in_ready, 1);
      end else begin
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
      end
    end
    check("stream_count", n_out - base, 100);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: stalled consumer fills the pipe with exactly S items
    base = n_in;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h1000_0000 * i + 32'h11, 32'h0000_0100 * i + 32'h22, 1'b0, 1'b0);
      if (i == 4) held = sum;
    end
    check("bp_accepted", n_in - base, S);
    check("bp_in_ready", in_ready, 0);
    check("bp_sum_stable", sum, held);
    check("bp_sum_head", sum, exp_q[0][W-1:0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    cycle(1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b1, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("bp_drained", exp_q.size(), 0);

    // Random stall
    base = n_out;
    n_in = 0;
    for (int i = 0; i < 2000; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("rand_drained", exp_q.size(), 0);
    check("rand_no_drop", n_out - base, n_in);

    // Reset mid-stream with results in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0101_0101 * (i + 1), 32'h0000_0F0F, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    @(posedge clk);
    #1;
    check("midrst_hold_out_valid", out_valid, 0);
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    base = n_out;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("midrst_no_stale", n_out - base, 0);
    directed("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined carry-ripple adder with valid/ready handshakes on both sides. It generalises the single-bit combinational half adder to a WIDTH-bit add with carry-in, carry-out and optional signed overflow. The carry chain is split across STAGES registered chunks, so wide adds close timing at full throughput. It sits between an operand producer and a result consumer, and both may stall.

## Interface
- WIDTH, 32: operand and result width in bits. Must be ≥ 2.
- STAGES, 4: number of pipeline stages. WIDTH % STAGES must be 0. CHUNK = WIDTH/STAGES bits are added per stage.
- clk  input  1: clock. All state updates on the rising edge.
- rst_n  input  1: reset. Asynchronous, active-low.
- in_valid  input  1: operands a, b, cin are valid.
- in_ready  output  1: the block can accept operands this cycle.
- a  input  WIDTH: operand A, unsigned (two's complement when overflow is used).
- b  input  WIDTH: operand B.
- cin  input  1: carry-in into bit 0.
- out_valid  output  1: sum, cout (and ovf) are valid.
- out_ready  input  1: the consumer accepts the result this cycle.
- sum  output  WIDTH: (a + b + cin) mod 2^WIDTH.
- cout  output  1: carry out of bit WIDTH-1.
- ovf  output  1: signed overflow. Present only when PIPELINED_ADDER_OVF_EN is defined.

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Each stage k (0..STAGES-1) holds: valid_k; the carry into the next chunk; result bits [k·CHUNK+CHUNK-1 : 0]; and operand bits still to be added.
- Stage k loads when !valid_k || ready_{k+1}. ready_STAGES is out_ready.
  - On load, stage k adds chunk k of its operands plus the incoming carry. The incoming carry is cin for stage 0, or the registered carry of stage k-1 otherwise.
  - It passes the lower result bits forward unchanged.
- in_ready = !valid_0 || ready_1. Backpressure propagates combinationally, so no bubbles are inserted while out_ready is held high.
- The last stage drives sum, cout (and ovf) directly from registers. out_valid = valid_{STAGES-1}.
- While a stage is stalled (valid and the downstream stage is not ready), it holds all of its contents stable.
- Arithmetic:
  - Each chunk add is CHUNK+1 bits wide. The MSB of the chunk add is the carry to the next stage.
  - cout is the carry out of the final chunk.
  - The add wraps modulo 2^WIDTH. 0xFFFF_FFFF + 0 + cin=1 gives sum 0, cout 1.
- STAGES = 1 degenerates to a single registered add with latency 1.

## Timing
- Reset (rst_n low, any time, including mid-transfer):
  - All valid_k = 0, so out_valid = 0.
  - sum = 0, cout = 0, ovf = 0.
  - in_ready = 1 from the first cycle after reset is deasserted.
  - In-flight operations are discarded; no partial result is ever presented.
- Latency: an operand accepted at edge t produces out_valid at edge t+STAGES-1, i.e. visible STAGES cycles after acceptance, given no stall.
- Throughput: one result per cycle while out_ready = 1.
- Full pipeline with out_ready = 0: all STAGES results are held, in_ready = 0, and sum is stable.
  - When out_ready rises, the output and input transfer in the same cycle and in_ready returns to 1 combinationally.
- Results leave in acceptance order; there is no reordering or dropping.
- in_valid may drop without a transfer; the block ignores a, b and cin when in_valid = 0.

## Configuration
- PIPELINED_ADDER_OVF_EN defined:
  - Port ovf exists.
  - ovf = carry into bit WIDTH-1 XOR cout, registered alongside sum and valid with out_valid.
  - Example: 0x7FFF_FFFF + 1 gives ovf = 1.
- Not defined: the ovf port and its logic are absent; all other behaviour is identical.

## Structure
- Package adder_pkg:
  - Default constants DEFAULT_WIDTH = 32 and DEFAULT_STAGES = 4.
  - A packed struct type for the per-stage payload: carry, partial sum, remaining operands.
  - Elaboration-time check function for WIDTH % STAGES == 0 and WIDTH ≥ 2.
- Sub-module adder_stage:
  - One register stage with a CHUNK-bit add, the valid/ready register slice and the hold logic.
  - Instantiated STAGES times through a generate loop.
- The top level contains only generate wiring, the output mapping and the optional overflow logic.

## Test plan
- Reset and idle: assert rst_n = 0 mid-stream with 3 results in flight. Required: out_valid = 0, sum = 0, cout = 0 while in reset; no stale result appears after release; in_ready = 1.
- Directed carries (WIDTH = 32, STAGES = 4):
  - 0x0000_00FF + 0x0000_0001, cin = 0 → sum 0x0000_0100, cout 0. The carry crosses a chunk boundary.
  - 0xFFFF_FFFF + 0x0000_0000, cin = 1 → sum 0, cout 1, out_valid exactly 4 cycles after acceptance.
- Streaming: 100 back-to-back random operand sets with out_ready = 1. Required: one result per cycle, in order, each equal to the reference model (a + b + cin).
- Backpressure: hold out_ready = 0 for 10 cycles while driving in_valid = 1. Required: exactly 4 operand sets accepted, in_ready = 0 afterwards, sum stable. Then release: the results drain in order with no loss or duplication.
- Random stall: randomise in_valid and out_ready at 50% each for 2000 cycles. Required: a scoreboard shows zero mismatches, zero drops and in-order delivery.
- Overflow (macro defined): 0x7FFF_FFFF + 0x0000_0001 → ovf 1, cout 0; 0x8000_0000 + 0x8000_0000 → sum 0, ovf 1, cout 1. With the macro undefined, the bench compiles without ovf.
